matrix_reader: RTL and testbench
================================

MATRIX_READER -- requirements
Module: matrix_reader

Interface
REQ-001 Parameter DATA_W, default 16, element width; SHALL match the storage write-port width.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  level request; sampled only in S_IDLE.
REQ-005 target_slot  input  2  storage slot to read, latched on accepted start.
REQ-006 busy  output  1  high in every state except S_IDLE and S_DONE.
REQ-007 done  output  1  high while in S_DONE.
REQ-008 err_empty  output  1  one-cycle pulse when the latched dims contain a zero.
REQ-009 dim_rd_en  output  1  dimension read strobe; dim_m/dim_n valid the next cycle.
REQ-010 dim_m, dim_n  input  3 each  stored dimensions of rd_slot_idx.
REQ-011 rd_slot_idx  output  2  slot addressed by dim and element reads.
REQ-012 rd_row, rd_col  output  3 each  element address.
REQ-013 rd_en  output  1  element read strobe; rd_data valid exactly one cycle later.
REQ-014 rd_data  input  DATA_W  element read data.
REQ-015 out_valid, out_ready  output/input  1 each  stream handshake; a transfer occurs when both are high on a rising edge.
REQ-016 out_data  output  DATA_W; out_row, out_col  output  3 each; out_last  output  1 (final element).
REQ-017 checksum  output  16  see Configuration.

Function
REQ-018 States: S_IDLE, S_DIM_REQ, S_DIM_WAIT, S_RD_REQ, S_RD_WAIT, S_OUT, S_DONE.
REQ-019 S_IDLE: on start=1, latch target_slot and go to S_DIM_REQ.
REQ-020 S_DIM_REQ: drive rd_slot_idx=latched slot, pulse dim_rd_en for one cycle, clear i,j to 0, go to S_DIM_WAIT.
REQ-021 S_DIM_WAIT: latch dim_m/dim_n; if either is 0, pulse err_empty and go to S_DONE, else go to S_RD_REQ.
REQ-022 S_RD_REQ: drive rd_row=i, rd_col=j, pulse rd_en for one cycle, go to S_RD_WAIT.
REQ-023 S_RD_WAIT: register rd_data into out_data, i/j into out_row/out_col, set out_last when i==m-1 and j==n-1, assert out_valid, go to S_OUT.
REQ-024 S_OUT: hold out_valid and all out_* stable until out_ready; on transfer drop out_valid; then if out_last go to S_DONE, else advance row-major (j wraps to 0 at n-1 and increments i) and go to S_RD_REQ.
REQ-025 Minimum throughput is one element per 3 cycles; elements are emitted row-major, exactly m*n transfers per request.
REQ-026 S_DONE: done=1; return to S_IDLE only once start=0 (level handshake, no re-trigger while start is held).
REQ-027 dim_rd_en, rd_en and err_empty SHALL be single-cycle pulses and never asserted in the same cycle.
REQ-028 start changes and target_slot changes after acceptance are ignored until S_IDLE.
REQ-029 Counters i,j are 3 bits; comparisons use the latched m-1, n-1 (no wrap beyond 7x7).

Reset
REQ-030 On rst_n=0 (any state, including mid-transfer): state=S_IDLE; busy, done, err_empty, dim_rd_en, rd_en, out_valid, out_last = 0; rd_slot_idx, rd_row, rd_col, out_data, out_row, out_col, checksum, i, j, latched slot/dims = 0.

Configuration
REQ-031 MATRIX_READER_CHECKSUM_EN defined: checksum clears on accepted start and adds out_data[15:0] modulo 2^16 on each transfer; final value stable in S_DONE.
REQ-032 MATRIX_READER_CHECKSUM_EN undefined: checksum tied to 0, no accumulator logic.

Structure
REQ-033 Shared package calc_pkg holds SLOT_W=2, DIM_W=3, DATA_W=16 constants and the reader state enumeration.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 Slot 1 holds 2x3 values 1..6, out_ready=1 -> six transfers (0,0)=1 ... (1,2)=6, out_last only on 6, done after; checksum=21 with macro.
REQ-036 Slot 0 dims 0x4 -> err_empty one pulse, zero transfers, no rd_en, done=1.
REQ-037 3x3 matrix, out_ready low 5 cycles on element (1,1) -> out_data/out_row/out_col held stable, no further rd_en until transfer.
REQ-038 start held high through S_DONE for 10 cycles -> no second read sequence; drop start -> S_IDLE next cycle.
REQ-039 rst_n pulsed low during S_OUT of a 4x4 read -> all outputs 0 immediately, next start re-reads from (0,0).
REQ-040 7x7 slot of 0xFFFF elements -> 49 transfers, last at (6,6), checksum=0xFFCF with macro, 0 without.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and the reader state encoding for matrix_reader.
package calc_pkg;

  localparam int SLOT_W = 2;   // storage slot index width
  localparam int DIM_W  = 3;   // row/column index and dimension width
  localparam int DATA_W = 16;  // default element width
  localparam int CSUM_W = 16;  // checksum width

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIM_REQ,
    S_DIM_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_OUT,
    S_DONE
  } reader_state_t;

endpackage

// File: rtl/matrix_reader.sv
// matrix_reader: on a start request, reads the dimensions of one storage slot,
// then streams every element of that slot in row-major order over a
// valid/ready interface. Optional checksum accumulator enabled by defining
// MATRIX_READER_CHECKSUM_EN; without it the checksum output is tied to zero.
module matrix_reader
  import calc_pkg::*;
#(
  parameter int DATA_W = calc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SLOT_W-1:0] target_slot,
  output logic              busy,
  output logic              done,
  output logic              err_empty,
  output logic              dim_rd_en,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  output logic [SLOT_W-1:0] rd_slot_idx,
  output logic [DIM_W-1:0]  rd_row,
  output logic [DIM_W-1:0]  rd_col,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              out_last,
  output logic [CSUM_W-1:0] checksum
);

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  reader_state_t     state_reg, state_next;
  logic [SLOT_W-1:0] slot_reg;
  logic [DIM_W-1:0]  m_reg, n_reg;
  logic [DIM_W-1:0]  i_reg, j_reg;
  logic [DIM_W-1:0]  m_last, n_last;
  logic [DATA_W-1:0] out_data_reg;
  logic [DIM_W-1:0]  out_row_reg, out_col_reg;
  logic              out_valid_reg, out_last_reg;
  logic              err_reg;
  logic              xfer;
  logic              dims_zero;
  logic              accept;

  // Last valid index in each dimension, taken from the latched dims.
  assign m_last = m_reg - DIM_ONE;
  assign n_last = n_reg - DIM_ONE;

  assign rd_slot_idx = slot_reg;
  assign rd_row      = i_reg;
  assign rd_col      = j_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_row     = out_row_reg;
  assign out_col     = out_col_reg;
  assign out_last    = out_last_reg;
  assign err_empty   = err_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    done       = (state_reg == S_DONE);
    dim_rd_en  = (state_reg == S_DIM_REQ);
    rd_en      = (state_reg == S_RD_REQ);
    accept     = (state_reg == S_IDLE) && start;
    xfer       = (state_reg == S_OUT) && out_valid_reg && out_ready;
    dims_zero  = (dim_m == '0) || (dim_n == '0);
    case (state_reg)
      S_IDLE:     if (start) state_next = S_DIM_REQ;
      S_DIM_REQ:  state_next = S_DIM_WAIT;
      S_DIM_WAIT: state_next = dims_zero ? S_DONE : S_RD_REQ;
      S_RD_REQ:   state_next = S_RD_WAIT;
      S_RD_WAIT:  state_next = S_OUT;
      S_OUT:      if (xfer) state_next = out_last_reg ? S_DONE : S_RD_REQ;
      S_DONE:     if (!start) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Datapath: slot/dims latching, row-major counters and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg      <= '0;
      m_reg         <= '0;
      n_reg         <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      out_data_reg  <= '0;
      out_row_reg   <= '0;
      out_col_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) slot_reg <= target_slot;
        end
        S_DIM_REQ: begin
          i_reg <= '0;
          j_reg <= '0;
        end
        S_DIM_WAIT: begin
          m_reg   <= dim_m;
          n_reg   <= dim_n;
          err_reg <= dims_zero;
        end
        S_RD_WAIT: begin
          out_data_reg  <= rd_data;
          out_row_reg   <= i_reg;
          out_col_reg   <= j_reg;
          out_last_reg  <= (i_reg == m_last) && (j_reg == n_last);
          out_valid_reg <= 1'b1;
        end
        S_OUT: begin
          if (xfer) begin
            out_valid_reg <= 1'b0;
            if (!out_last_reg) begin
              if (j_reg == n_last) begin
                j_reg <= '0;
                i_reg <= i_reg + DIM_ONE;
              end else begin
                j_reg <= j_reg + DIM_ONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MATRIX_READER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_reg;
  logic [CSUM_W-1:0] csum_term;

  assign csum_term = CSUM_W'(out_data_reg);
  assign checksum  = csum_reg;

  // Running modulo-2^16 sum of transferred elements, restarted per request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      csum_reg <= '0;
    else if (accept) csum_reg <= '0;
    else if (xfer)   csum_reg <= csum_reg + csum_term;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_reader.sv
// Testbench for matrix_reader: table of read requests against a small storage
// model, plus hand-written reset-in-flight and explicit-value sequences.
module tb_matrix_reader;
  import calc_pkg::*;

`ifdef MATRIX_READER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  target_slot = 2'd0;
  logic        busy, done, err_empty, dim_rd_en, rd_en;
  logic [2:0]  dim_m = 3'd0;
  logic [2:0]  dim_n = 3'd0;
  logic [1:0]  rd_slot_idx;
  logic [2:0]  rd_row, rd_col;
  logic [15:0] rd_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [2:0]  out_row, out_col;
  logic        out_last;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  matrix_reader #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target_slot(target_slot),
    .busy(busy), .done(done), .err_empty(err_empty), .dim_rd_en(dim_rd_en),
    .dim_m(dim_m), .dim_n(dim_n), .rd_slot_idx(rd_slot_idx),
    .rd_row(rd_row), .rd_col(rd_col), .rd_en(rd_en), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .checksum(checksum)
  );

  // Storage model: one-cycle registered reads for dims and elements.
  logic [15:0] mem [4][8][8];
  logic [2:0]  mem_m [4];
  logic [2:0]  mem_n [4];

  always @(posedge clk) begin
    if (dim_rd_en) begin
      dim_m <= mem_m[rd_slot_idx];
      dim_n <= mem_n[rd_slot_idx];
    end
    if (rd_en) rd_data <= mem[rd_slot_idx][rd_row][rd_col];
  end

  typedef struct packed {
    logic [2:0]  row;
    logic [2:0]  col;
    logic [15:0] data;
    logic        last;
  } xfer_t;

  typedef struct {
    int          slot;
    int          m;
    int          n;
    int          st_r;
    int          st_c;
    int          st_n;
    int          exp_err;
    logic [15:0] csum;
  } vec_t;

  xfer_t xq[$];
  int n_pass = 0;
  int n_total = 0;
  int cnt_dim, cnt_rd, cnt_err, overlap, stall_viol, stall_rd, held_viol;
  logic [15:0] csum_at_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one read request, optionally stalling one element, then hold start
  // through S_DONE for 10 cycles and release it.
  task automatic run_read(input int slot, input int st_r, input int st_c,
                          input int st_n, input int alt_slot);
    int    stalls;
    int    cyc;
    bit    prev_stall;
    xfer_t held;
    xq.delete();
    cnt_dim = 0; cnt_rd = 0; cnt_err = 0; overlap = 0;
    stall_viol = 0; stall_rd = 0; held_viol = 0;
    stalls = 0; prev_stall = 1'b0; cyc = 0;
    held = '0;
    @(negedge clk);
    start = 1'b1;
    target_slot = 2'(slot);
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) target_slot = 2'(alt_slot);
      if (dim_rd_en) cnt_dim++;
      if (rd_en) cnt_rd++;
      if (err_empty) cnt_err++;
      if (int'(dim_rd_en) + int'(rd_en) + int'(err_empty) > 1) overlap++;
      if (prev_stall) begin
        if (!out_valid || (xfer_t'({out_row, out_col, out_data, out_last}) != held))
          stall_viol++;
        if (rd_en) stall_rd++;
      end
      out_ready = 1'b1;
      if (out_valid && int'(out_row) == st_r && int'(out_col) == st_c && stalls < st_n) begin
        out_ready = 1'b0;
        stalls++;
      end
      prev_stall = out_valid && !out_ready;
      held = {out_row, out_col, out_data, out_last};
      if (out_valid && out_ready) begin
        xq.push_back(held);
        $display("xfer slot %0d (%0d,%0d) data=0x%04h last=%0d",
                 slot, out_row, out_col, out_data, out_last);
      end
    end while (!done && cyc < 3000);
    check("done reached", 32'(done), 32'd1);
    csum_at_done = checksum;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!done || busy || dim_rd_en || rd_en || checksum !== csum_at_done) held_viol++;
      if (err_empty) cnt_err++;
    end
    start = 1'b0;
    @(negedge clk);
    check("idle after start drop", 32'({done, busy}), 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    int    cyc;
    bit    reached;
    xfer_t e;
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          case (s)
            1:       mem[s][r][c] = 16'(r * 3 + c + 1);
            2:       mem[s][r][c] = 16'(16'h1000 + r * 16 + c);
            3:       mem[s][r][c] = 16'hFFFF;
            default: mem[s][r][c] = 16'h0000;
          endcase
    mem_m[0] = 3'd0; mem_n[0] = 3'd4;
    mem_m[1] = 3'd2; mem_n[1] = 3'd3;
    mem_m[2] = 3'd3; mem_n[2] = 3'd3;
    mem_m[3] = 3'd7; mem_n[3] = 3'd7;

    //           slot m  n  st_r st_c st_n err csum
    vecs[0] = '{1,   2, 3, -1,  -1,  0,   0,  16'd21};
    vecs[1] = '{0,   0, 4, -1,  -1,  0,   1,  16'd0};
    vecs[2] = '{2,   3, 3,  1,   1,  5,   0,  16'h9099};
    vecs[3] = '{3,   7, 7, -1,  -1,  0,   0,  16'hFFCF};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset strobes", 32'({busy, done, err_empty, dim_rd_en, rd_en, out_valid, out_last}), 32'd0);
    check("reset addr", 32'({rd_slot_idx, rd_row, rd_col, out_row, out_col}), 32'd0);
    check("reset data", 32'({out_data, checksum}), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run_read(vecs[v].slot, vecs[v].st_r, vecs[v].st_c, vecs[v].st_n, (vecs[v].slot + 1) % 4);
      check($sformatf("v%0d transfers", v), 32'(xq.size()), 32'(vecs[v].m * vecs[v].n));
      check($sformatf("v%0d dim_rd_en pulses", v), 32'(cnt_dim), 32'd1);
      check($sformatf("v%0d rd_en pulses", v), 32'(cnt_rd), 32'(vecs[v].m * vecs[v].n));
      check($sformatf("v%0d err_empty pulses", v), 32'(cnt_err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d strobe overlap", v), 32'(overlap), 32'd0);
      check($sformatf("v%0d stall stability", v), 32'(stall_viol), 32'd0);
      check($sformatf("v%0d rd_en during stall", v), 32'(stall_rd), 32'd0);
      check($sformatf("v%0d done hold", v), 32'(held_viol), 32'd0);
      check($sformatf("v%0d checksum", v), 32'(csum_at_done), 32'(CSUM_ON ? vecs[v].csum : 16'd0));
      for (int k = 0; k < xq.size() && k < 64; k++) begin
        e.row  = 3'(k / vecs[v].n);
        e.col  = 3'(k % vecs[v].n);
        e.data = mem[vecs[v].slot][k / vecs[v].n][k % vecs[v].n];
        e.last = (k == vecs[v].m * vecs[v].n - 1);
        check($sformatf("v%0d element %0d", v, k), 32'(xq[k]), 32'(e));
      end
    end

    // Slot 1 again, against literal values 1..6 with last only on 6.
    run_read(1, -1, -1, 0, 0);
    check("slot1 count", 32'(xq.size()), 32'd6);
    for (int k = 0; k < xq.size() && k < 6; k++) begin
      check($sformatf("slot1 value %0d", k), 32'(xq[k].data), 32'(k + 1));
      check($sformatf("slot1 last %0d", k), 32'(xq[k].last), 32'(k == 5));
    end

    // Reset in the middle of a 4x4 read while element (1,2) is stalled.
    mem_m[2] = 3'd4; mem_n[2] = 3'd4;
    @(negedge clk);
    start = 1'b1;
    target_slot = 2'd2;
    out_ready = 1'b1;
    cyc = 0;
    reached = 1'b0;
    while (!reached && cyc < 500) begin
      @(negedge clk);
      cyc++;
      reached = out_valid && out_row == 3'd1 && out_col == 3'd2;
      out_ready = !reached;
    end
    check("4x4 reached (1,2)", 32'(reached), 32'd1);
    check("4x4 element before reset", 32'(out_data), 32'h1012);
    #2 rst_n = 1'b0;
    #1;
    check("async reset strobes", 32'({busy, done, err_empty, dim_rd_en, rd_en, out_valid, out_last}), 32'd0);
    check("async reset addr", 32'({rd_slot_idx, rd_row, rd_col, out_row, out_col}), 32'd0);
    check("async reset data", 32'({out_data, checksum}), 32'd0);
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    run_read(2, -1, -1, 0, 2);
    check("4x4 count after reset", 32'(xq.size()), 32'd16);
    if (xq.size() > 0)
      check("4x4 first after reset", 32'(xq[0]), 32'({3'd0, 3'd0, 16'h1000, 1'b0}));
    else
      check("4x4 first after reset", 32'd0, 32'd1);
    check("4x4 checksum", 32'(csum_at_done), 32'(CSUM_ON ? 16'h0198 : 16'd0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
